nes_joypad_port: RTL and testbench
==================================

// Module: nes_joypad_port
// PURPOSE
//  Downstream consumer of the two dualshock_controller receive bytes; one instance per NES pad.
//  Filters the raw bytes, maps them to NES button order and adds turbo A/B from triangle/square.
//  Presents the result as the NES $4016/$4017 serial port: strobe-latched, shifted on falling joy_clk.
//  Replaces the inline joypad shift logic and the separate Autofire instances in the NES top level.
// PARAMETERS
//  CLK_FREQ     21_477_272  clk frequency in Hz
//  TURBO_HZ     15          turbo press rate (full on/off cycles per second)
//  HALF_PERIOD  CLK_FREQ/(2*TURBO_HZ)  clocks per turbo phase; sims override to a small value, >=2
// PORTS
//  clk         in   1  system clock, all logic on rising edge
//  reset       in   1  asynchronous, active-high reset
//  raw_b0      in   8  dualshock byte 1, active-low: {L,D,R,U,St,R3,L3,Se} = bits[7:0]
//  raw_b1      in   8  dualshock byte 2, active-low: {Sq,X,O,Tri,R1,L1,R2,L2} = bits[7:0]
//  loader_btn  in   8  UART-injected buttons, active-high, NES order, ORed in
//  strobe      in   1  NES joypad strobe (level)
//  joy_clk     in   1  NES joypad read clock for this port
//  dout        out  1  serial button bit to CPU
//  btn_state   out  8  current filtered NES button byte {R,L,D,U,Start,Select,B,A}, active-high
//  read_count  out  4  bits shifted since last strobe, saturates at 8
// BEHAVIOUR
//  Reset values (asynchronous): dout=0, btn_state=0, read_count=0.
//  Reset values of internal state: stage/filter regs=8'hFF (all released), shift reg=0, joy_clk_d=0,
//  turbo cnt=0, turbo phase=1.
//  Input filter:
//   - s1<=raw, s2<=s1 every cycle; filt<=s2 only when s1==s2 (per byte); otherwise filt holds.
//   - Effect: a raw change reaches filt 3 cycles later; glitches shorter than 2 cycles never pass.
//  Turbo generator:
//   - held_a=~filt1[4] (triangle), held_b=~filt1[7] (square).
//   - Neither held: cnt=0, phase=1.
//   - Either held: cnt increments; at cnt==HALF_PERIOD-1, cnt<=0 and phase toggles.
//   - turbo_a=held_a&phase, turbo_b=held_b&phase; a press therefore asserts turbo on its first cycle.
//  Mapping (combinational off filt):
//   - nes = {~f0[5],~f0[7],~f0[6],~f0[4],~f0[3],~f0[0], ~f1[6]|turbo_b, ~f1[5]|turbo_a}.
//   - O=A, X=B; btn_state is nes, registered.
//  Serial port (joy_clk_d<=joy_clk every cycle; fall = joy_clk_d & ~joy_clk):
//   - strobe=1: sh<=btn_state|loader_btn every cycle, read_count<=0. Strobe has priority over fall.
//   - strobe=0 & fall: sh<={1'b1,sh[7:1]}, read_count<=min(read_count+1,8).
//   - dout=sh[0], registered copy. First bit (A) is valid 1 cycle after latch.
//   - After 8 shifts dout=1 forever, matching an official pad, until next strobe.
//   - joy_clk edges while strobe=1 are ignored.
//  Width rule: cnt is $clog2(HALF_PERIOD) bits; wrap is by compare, never by overflow.
//  Reset mid-read: sh clears, so dout=0 until the next strobe latches.
// TESTING
//  1 Reset: assert reset mid-cycle -> dout=0, btn_state=0, read_count=0 immediately (async).
//  2 Mapping: raw_b0=8'hDF (R), raw_b1=8'hDF (O); strobe pulse, 8 joy_clk falls -> dout sequence
//    A..R = 1,0,0,0,0,0,0,1, then a 9th fall -> dout=1, read_count=8.
//  3 Filter: 1-cycle raw_b0 glitch to 8'h00 -> btn_state unchanged; 2-cycle hold -> changes after 3 clk.
//  4 Turbo (HALF_PERIOD=4): hold triangle -> btn_state[0] toggles 1,0,1 every 4 clk;
//    release -> 0 and phase resets.
//  5 Priority: strobe=1 coincident with a joy_clk fall -> read_count=0, sh reloaded; loader_btn=8'h08
//    with no pad -> Start read on 4th bit.
//  6 Mid-read reset after 3 shifts -> dout=0; new strobe -> correct byte from bit 0.

Source files
------------

// File: rtl/nes_joypad_port.sv
// nes_joypad_port: one NES controller port fed by the two dualshock receive bytes.
// The raw active-low bytes are debounced, mapped into NES button order with turbo
// A/B from triangle/square, and presented as the $4016/$4017 serial shift port.
//
// Ports:
//   clk_i          system clock, rising edge
//   reset_i        asynchronous active-high reset
//   raw_b0_i       dualshock byte 1, active-low {L,D,R,U,St,R3,L3,Se}
//   raw_b1_i       dualshock byte 2, active-low {Sq,X,O,Tri,R1,L1,R2,L2}
//   loader_btn_i   injected buttons, active-high, NES order, ORed in at latch
//   strobe_i       NES strobe level; while high the shift register reloads
//   joy_clk_i      NES read clock; falling edge shifts the next bit out
//   dout_o         serial button bit to the CPU
//   btn_state_o    filtered NES button byte {R,L,D,U,Start,Select,B,A}, active-high
//   read_count_o   bits shifted since last strobe, saturates at 8
module nes_joypad_port #(
  parameter int unsigned CLK_FREQ    = 21_477_272,
  parameter int unsigned TURBO_HZ    = 15,
  parameter int unsigned HALF_PERIOD = CLK_FREQ / (2 * TURBO_HZ)
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [7:0] raw_b0_i,
  input  logic [7:0] raw_b1_i,
  input  logic [7:0] loader_btn_i,
  input  logic       strobe_i,
  input  logic       joy_clk_i,
  output logic       dout_o,
  output logic [7:0] btn_state_o,
  output logic [3:0] read_count_o
);

  localparam int unsigned CntW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(HALF_PERIOD - 1);

  // Two-stage sampler plus a filter register per byte.
  logic [7:0] s1_b0_q, s2_b0_q, filt_b0_q;
  logic [7:0] s1_b1_q, s2_b1_q, filt_b1_q;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            phase_q, phase_d;
  logic [7:0]      btn_q, btn_d;
  logic [7:0]      sh_q, sh_d;
  logic [3:0]      rd_cnt_q, rd_cnt_d;
  logic            dout_q;
  logic            joy_clk_q;

  logic held_a, held_b, turbo_a, turbo_b, fall;

  // Buttons the NES has no use for.
  logic unused_bits;
  assign unused_bits = ^{filt_b0_q[2:1], filt_b1_q[3:0]};

  assign held_a  = ~filt_b1_q[4];
  assign held_b  = ~filt_b1_q[7];
  assign turbo_a = held_a & phase_q;
  assign turbo_b = held_b & phase_q;
  assign fall    = joy_clk_q & ~joy_clk_i;

  // Turbo phase only runs while a turbo button is held; release restarts it
  // so the next press asserts immediately.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!(held_a || held_b)) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q == CntLast) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // O is A, X is B.
  always_comb begin
    btn_d = {~filt_b0_q[5], ~filt_b0_q[7], ~filt_b0_q[6], ~filt_b0_q[4],
             ~filt_b0_q[3], ~filt_b0_q[0], ~filt_b1_q[6] | turbo_b,
             ~filt_b1_q[5] | turbo_a};
  end

  // Strobe wins over a coincident fall. Ones shift in so an over-read returns 1.
  always_comb begin
    sh_d     = sh_q;
    rd_cnt_d = rd_cnt_q;
    if (strobe_i) begin
      sh_d     = btn_q | loader_btn_i;
      rd_cnt_d = 4'd0;
    end else if (fall) begin
      sh_d = {1'b1, sh_q[7:1]};
      if (rd_cnt_q < 4'd8) rd_cnt_d = rd_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      s1_b0_q   <= 8'hFF;
      s2_b0_q   <= 8'hFF;
      filt_b0_q <= 8'hFF;
      s1_b1_q   <= 8'hFF;
      s2_b1_q   <= 8'hFF;
      filt_b1_q <= 8'hFF;
      cnt_q     <= '0;
      phase_q   <= 1'b1;
      btn_q     <= 8'h00;
      sh_q      <= 8'h00;
      rd_cnt_q  <= 4'd0;
      dout_q    <= 1'b0;
      joy_clk_q <= 1'b0;
    end else begin
      s1_b0_q <= raw_b0_i;
      s2_b0_q <= s1_b0_q;
      s1_b1_q <= raw_b1_i;
      s2_b1_q <= s1_b1_q;
      // Accept a byte only once it has been stable over two samples.
      if (s1_b0_q == s2_b0_q) filt_b0_q <= s2_b0_q;
      if (s1_b1_q == s2_b1_q) filt_b1_q <= s2_b1_q;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      btn_q     <= btn_d;
      sh_q      <= sh_d;
      rd_cnt_q  <= rd_cnt_d;
      dout_q    <= sh_q[0];
      joy_clk_q <= joy_clk_i;
    end
  end

  assign dout_o       = dout_q;
  assign btn_state_o  = btn_q;
  assign read_count_o = rd_cnt_q;

endmodule

// File: tb/tb_nes_joypad_port.sv
module tb_nes_joypad_port;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] raw_b0, raw_b1, loader_btn;
  logic       strobe, joy_clk;
  logic       dout;
  logic [7:0] btn_state;
  logic [3:0] read_count;

  nes_joypad_port #(
    .CLK_FREQ   (1000),
    .TURBO_HZ   (1),
    .HALF_PERIOD(4)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .raw_b0_i    (raw_b0),
    .raw_b1_i    (raw_b1),
    .loader_btn_i(loader_btn),
    .strobe_i    (strobe),
    .joy_clk_i   (joy_clk),
    .dout_o      (dout),
    .btn_state_o (btn_state),
    .read_count_o(read_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         sig;   // 0 dout, 1 btn_state, 2 read_count
    logic [7:0] exp;
  } chk_t;

  chk_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Monitor: every falling edge drains the scoreboard against live outputs.
  always @(negedge clk) begin
    chk_t       c;
    logic [7:0] act;
    while (sb_q.size() > 0) begin
      c = sb_q.pop_front();
      case (c.sig)
        0:       act = {7'b0, dout};
        1:       act = btn_state;
        default: act = {4'b0, read_count};
      endcase
      n_checks++;
      if (act !== c.exp) begin
        n_fail++;
        $display("FAIL %s: got %h, expected %h at %0t", c.name, act, c.exp, $time);
      end
    end
  end

  task automatic push(input string name, input int sig, input logic [7:0] exp);
    chk_t c;
    c.name = name;
    c.sig  = sig;
    c.exp  = exp;
    sb_q.push_back(c);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_strobe();
    strobe = 1'b1;
    tick(2);
    strobe = 1'b0;
    tick(2);
  endtask

  task automatic do_shift();
    joy_clk = 1'b1;
    tick(2);
    joy_clk = 1'b0;
    tick(2);
  endtask

  // Strobe then clock out a full byte plus the over-read bit.
  task automatic read_byte(input string tag, input logic [7:0] exp_byte);
    logic [7:0] b;
    b = exp_byte;
    do_strobe();
    push({tag, " bit0"}, 0, {7'b0, b[0]});
    push({tag, " cnt0"}, 2, 8'd0);
    for (int k = 1; k < 8; k++) begin
      do_shift();
      push($sformatf("%s bit%0d", tag, k), 0, {7'b0, b[k]});
      push($sformatf("%s cnt%0d", tag, k), 2, 8'(k));
    end
    do_shift();
    push({tag, " over1"}, 0, 8'd1);
    push({tag, " cnt8"}, 2, 8'd8);
  endtask

  logic [7:0] texp;

  initial begin
    reset = 1'b1; raw_b0 = 8'hFF; raw_b1 = 8'hFF; loader_btn = 8'h00;
    strobe = 1'b0; joy_clk = 1'b0;
    tick(2);
    push("rst dout", 0, 8'h00);
    push("rst btn", 1, 8'h00);
    push("rst cnt", 2, 8'h00);
    tick(1);
    reset = 1'b0;
    tick(2);

    // Mapping: R on byte 1, O (A) on byte 2.
    raw_b0 = 8'hDF; raw_b1 = 8'hDF;
    tick(5);
    push("map btn", 1, 8'h81);
    read_byte("map", 8'h81);
    do_shift();
    push("map over2", 0, 8'd1);
    push("map sat", 2, 8'd8);
    tick(1);

    // Reset asserted mid-cycle must clear outputs before the next edge.
    #1 reset = 1'b1;
    push("async dout", 0, 8'h00);
    push("async btn", 1, 8'h00);
    push("async cnt", 2, 8'h00);
    raw_b0 = 8'hFF; raw_b1 = 8'hFF;
    tick(1);
    reset = 1'b0;
    tick(5);

    // Filter: single-cycle glitch is rejected.
    raw_b0 = 8'h00;
    tick(1);
    raw_b0 = 8'hFF;
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      push($sformatf("glitch c%0d", k), 1, 8'h00);
    end
    // Two-cycle hold passes: btn changes on the 4th edge, held for two cycles.
    raw_b0 = 8'h00;
    tick(2);
    raw_b0 = 8'hFF;
    tick(1); push("hold e3", 1, 8'h00);
    tick(1); push("hold e4", 1, 8'hFC);
    tick(1); push("hold e5", 1, 8'hFC);
    tick(1); push("hold e6", 1, 8'h00);
    tick(3);

    // Turbo A from triangle, 4 clocks per phase.
    raw_b1 = 8'hEF;
    for (int k = 1; k <= 15; k++) begin
      tick(1);
      texp = (k < 4) ? 8'h00 : ((((k - 4) / 4) % 2 == 0) ? 8'h01 : 8'h00);
      push($sformatf("turbo e%0d", k), 1, texp);
    end
    raw_b1 = 8'hFF;
    for (int k = 16; k <= 19; k++) begin
      tick(1);
      push($sformatf("release e%0d", k), 1, 8'h00);
    end
    // Re-press: phase restarted, so turbo asserts on the first filtered cycle.
    raw_b1 = 8'hEF;
    for (int k = 20; k <= 26; k++) begin
      tick(1);
      push($sformatf("repress e%0d", k), 1, (k >= 23) ? 8'h01 : 8'h00);
    end
    raw_b1 = 8'hFF;
    tick(6);

    // Priority: strobe coincident with a fall; loader Start only.
    loader_btn = 8'h08;
    do_strobe();
    do_shift();
    do_shift();
    push("pri pre cnt", 2, 8'd2);
    joy_clk = 1'b1;
    tick(2);
    joy_clk = 1'b0;
    strobe  = 1'b1;
    tick(1);
    push("pri cnt", 2, 8'd0);
    strobe = 1'b0;
    tick(2);
    push("pri bit0", 0, 8'd0);
    do_shift(); push("pri bit1", 0, 8'd0);
    do_shift(); push("pri bit2", 0, 8'd0);
    do_shift(); push("pri bit3", 0, 8'd1);
    push("pri cnt3", 2, 8'd3);
    do_shift(); push("pri bit4", 0, 8'd0);
    loader_btn = 8'h00;

    // Mid-read reset: Start + A.
    raw_b0 = 8'hF7; raw_b1 = 8'hDF;
    tick(5);
    push("mid btn", 1, 8'h09);
    do_strobe();
    push("mid bit0", 0, 8'd1);
    do_shift(); do_shift(); do_shift();
    push("mid bit3", 0, 8'd1);
    push("mid cnt3", 2, 8'd3);
    tick(1);
    reset = 1'b1;
    push("mid rst dout", 0, 8'd0);
    push("mid rst cnt", 2, 8'd0);
    tick(1);
    reset = 1'b0;
    tick(5);
    push("post rst dout", 0, 8'd0);
    push("post rst btn", 1, 8'h09);
    read_byte("reread", 8'h09);

    tick(2);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
